// File: rtl/timekeeper_pkg.sv
// rtl/timekeeper_pkg.sv - shared constants and helpers for the timekeeper
package timekeeper_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEFAULT_WIDTH = 16;

    // Prescaler counter width; a PRESCALE of 1 still needs a one-bit register.
    function automatic int presc_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/tk_prescaler.sv
// rtl/tk_prescaler.sv - clock prescaler producing a one-cycle step request
module tk_prescaler
    import timekeeper_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic step
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pc;

    assign step = en && (pc == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pc <= '0;
        end else if (step) begin
            pc <= '0;
        end else if (en) begin
            pc <= pc + PW'(1);
        end
    end

endmodule

// File: rtl/timekeeper_multi.sv
// rtl/timekeeper_multi.sv - prescaled up/down time counter with wrap pulse and sticky alarm
module timekeeper_multi
    import timekeeper_pkg::*;
#(
    parameter int                WIDTH     = DEFAULT_WIDTH,
    parameter int                PRESCALE  = 1,
    parameter logic [WIDTH-1:0]  MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             alarm_en,
    input  logic [WIDTH-1:0] alarm_val,
    input  logic             alarm_clr,
    output logic [WIDTH-1:0] cur_time,
    output logic             tick,
    output logic             wrap,
    output logic             alarm
);

    logic             step;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;
    logic [WIDTH-1:0] load_clamped;
    logic             alarm_set;

    tk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (load),
        .step  (step)
    );

    // Wrap is decided by explicit compare so reduced ranges never rely on overflow.
    always_comb begin
        step_val  = cur_time;
        step_wrap = 1'b0;
        if (dir == DIR_UP) begin
            if (cur_time == MAX_COUNT) begin
                step_val  = '0;
                step_wrap = 1'b1;
            end else begin
                step_val = cur_time + WIDTH'(1);
            end
        end else begin
            if (cur_time == '0) begin
                step_val  = MAX_COUNT;
                step_wrap = 1'b1;
            end else begin
                step_val = cur_time - WIDTH'(1);
            end
        end
    end

    assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
    assign alarm_set    = step && !load && alarm_en && (step_val == alarm_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_time <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            alarm <= alarm_set | (alarm & ~alarm_clr);
            if (load) begin
                cur_time <= load_clamped;
                tick     <= 1'b0;
                wrap     <= 1'b0;
            end else if (step) begin
                cur_time <= step_val;
                tick     <= 1'b1;
                wrap     <= step_wrap;
            end else begin
                tick <= 1'b0;
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timekeeper_multi.sv
// tb/tb_timekeeper_multi.sv - three configurations of timekeeper_multi against a behavioural model
module tb_timekeeper_multi;

    typedef struct packed {
        int t;
        int ph;
        bit tick;
        bit wrap;
        bit alarm;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic en [3];
    logic dir [3];
    logic load [3];
    logic aen [3];
    logic aclr [3];
    int   lv [3];
    int   av [3];

    logic [15:0] ct0;
    logic [3:0]  ct1;
    logic [3:0]  ct2;
    logic        tk [3];
    logic        wr [3];
    logic        al [3];

    int total = 0;
    int passed = 0;

    int pcfg [3] = '{1, 3, 4};
    int mcfg [3] = '{65535, 9, 12};
    mstate_t ms [3];
    bit valid [3] = '{0, 0, 0};

    timekeeper_multi u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_val(lv[0][15:0]), .alarm_en(aen[0]), .alarm_val(av[0][15:0]),
        .alarm_clr(aclr[0]), .cur_time(ct0), .tick(tk[0]), .wrap(wr[0]), .alarm(al[0])
    );

    timekeeper_multi #(.WIDTH(4), .PRESCALE(3), .MAX_COUNT(4'd9)) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_val(lv[1][3:0]), .alarm_en(aen[1]), .alarm_val(av[1][3:0]),
        .alarm_clr(aclr[1]), .cur_time(ct1), .tick(tk[1]), .wrap(wr[1]), .alarm(al[1])
    );

    timekeeper_multi #(.WIDTH(4), .PRESCALE(4), .MAX_COUNT(4'd12)) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .dir(dir[2]), .load(load[2]),
        .load_val(lv[2][3:0]), .alarm_en(aen[2]), .alarm_val(av[2][3:0]),
        .alarm_clr(aclr[2]), .cur_time(ct2), .tick(tk[2]), .wrap(wr[2]), .alarm(al[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // Modular arithmetic view: counting walks a ring of MAX+1 values, steps every P enabled cycles.
    function automatic mstate_t model(input mstate_t s, input int p, input int m,
                                      input bit r, input bit e, input bit d, input bit ld,
                                      input int lval, input bit ae, input int aval, input bit ac);
        mstate_t n;
        bit fire;
        n = s;
        n.tick = 0;
        n.wrap = 0;
        if (r) return '0;
        if (ld) begin
            n.t = (lval > m) ? m : lval;
            n.ph = 0;
            n.alarm = s.alarm && !ac;
            return n;
        end
        fire = e && ((s.ph + 1) % p == 0);
        if (e) n.ph = (s.ph + 1) % p;
        if (fire) begin
            n.t = d ? (s.t + m) % (m + 1) : (s.t + 1) % (m + 1);
            n.tick = 1;
            n.wrap = d ? (s.t == 0) : (s.t == m);
        end
        n.alarm = (fire && ae && n.t == aval) || (s.alarm && !ac);
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ms[i] = model(ms[i], pcfg[i], mcfg[i], rst[i], en[i], dir[i], load[i],
                          lv[i], aen[i], av[i], aclr[i]);
            if (rst[i]) valid[i] = 1;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            int act;
            act = (i == 0) ? int'(ct0) : (i == 1) ? int'(ct1) : int'(ct2);
            if (valid[i]) begin
                chk($sformatf("model_cur_u%0d", i), act, ms[i].t);
                chk($sformatf("model_tick_u%0d", i), int'(tk[i]), int'(ms[i].tick));
                chk($sformatf("model_wrap_u%0d", i), int'(wr[i]), int'(ms[i].wrap));
                chk($sformatf("model_alarm_u%0d", i), int'(al[i]), int'(ms[i].alarm));
            end
        end
    end

    initial begin
        int ticks;
        int wraps;
        int seq [8];
        ticks = 0;
        wraps = 0;
        seq = '{6, 5, 4, 3, 2, 1, 0, 9};
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1; en[i] = 0; dir[i] = 0; load[i] = 0;
            aen[i] = 0; aclr[i] = 0; lv[i] = 0; av[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 0;
        chk("reset_cur_u0", int'(ct0), 0);
        chk("reset_alarm_u0", int'(al[0]), 0);
        en[0] = 1;
        en[1] = 1;

        // free-running default counter and the prescaled 0..9 counter together
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                chk("t1_cur", int'(ct0), k);
                chk("t1_tick", int'(tk[0]), 1);
                chk("t1_wrap", int'(wr[0]), 0);
            end
            ticks += int'(tk[1]);
            wraps += int'(wr[1]);
        end
        chk("t2_ticks", ticks, 10);
        chk("t2_wraps", wraps, 1);
        chk("t2_final", int'(ct1), 0);

        load[1] = 1; lv[1] = 7; dir[1] = 1;
        @(negedge clk);
        load[1] = 0;
        chk("t3_load7", int'(ct1), 7);
        chk("t3_load_tick", int'(tk[1]), 0);
        for (int j = 0; j < 8; j++) begin
            repeat (3) @(negedge clk);
            chk("t3_down", int'(ct1), seq[j]);
            chk("t3_wrap", int'(wr[1]), (seq[j] == 9) ? 1 : 0);
        end
        load[1] = 1; lv[1] = 15;
        @(negedge clk);
        load[1] = 0;
        chk("t3_clamp", int'(ct1), 9);

        // en pause mid-prescale on u2
        en[2] = 1;
        repeat (2) @(negedge clk);
        en[2] = 0;
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold", int'(ct2), 0);
        end
        en[2] = 1;
        @(negedge clk);
        chk("t5_pre", int'(ct2), 0);
        chk("t5_pre_tick", int'(tk[2]), 0);
        @(negedge clk);
        chk("t5_step", int'(ct2), 1);
        chk("t5_step_tick", int'(tk[2]), 1);

        // reset beats load and clears a set alarm mid-prescale
        load[2] = 1; lv[2] = 8; aen[2] = 1; av[2] = 9;
        @(negedge clk);
        load[2] = 0;
        chk("t6_load", int'(ct2), 8);
        repeat (4) @(negedge clk);
        chk("t6_nine", int'(ct2), 9);
        chk("t6_alarm", int'(al[2]), 1);
        repeat (2) @(negedge clk);
        chk("t6_hold", int'(ct2), 9);
        rst[2] = 1; load[2] = 1; lv[2] = 5;
        @(negedge clk);
        rst[2] = 0; load[2] = 0;
        chk("t6_rst_cur", int'(ct2), 0);
        chk("t6_rst_tick", int'(tk[2]), 0);
        chk("t6_rst_wrap", int'(wr[2]), 0);
        chk("t6_rst_alarm", int'(al[2]), 0);

        // alarm on the default counter
        aen[0] = 1; av[0] = 5; load[0] = 1; lv[0] = 0;
        @(negedge clk);
        load[0] = 0;
        chk("t4_load0", int'(ct0), 0);
        for (int v = 1; v <= 7; v++) begin
            @(negedge clk);
            chk("t4_cur", int'(ct0), v);
            chk("t4_alarm", int'(al[0]), (v >= 5) ? 1 : 0);
        end
        aclr[0] = 1;
        @(negedge clk);
        aclr[0] = 0;
        chk("t4_cleared", int'(al[0]), 0);
        load[0] = 1; lv[0] = 5;
        @(negedge clk);
        chk("t4_load5_cur", int'(ct0), 5);
        chk("t4_load5_alarm", int'(al[0]), 0);
        lv[0] = 4;
        @(negedge clk);
        load[0] = 0;
        aclr[0] = 1;
        @(negedge clk);
        aclr[0] = 0;
        chk("t4_setclr_cur", int'(ct0), 5);
        chk("t4_setclr_alarm", int'(al[0]), 1);

        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                rst[i]  = ($urandom % 97) == 0;
                load[i] = ($urandom % 13) == 0;
                lv[i]   = (i == 0) ? int'($urandom % 24) : int'($urandom % 16);
                en[i]   = ($urandom % 5) != 0;
                if ($urandom % 9 == 0) dir[i] = ~dir[i];
                aen[i]  = ($urandom % 4) != 0;
                if ($urandom % 32 == 0) av[i] = (i == 0) ? int'($urandom % 24) : int'($urandom % 16);
                aclr[i] = ($urandom % 11) == 0;
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timekeeper_multi.md
Name: timekeeper_multi

Overview:
Parametrised successor to the free-running time counter. Adds:
- configurable width and wrap limit
- clock prescaler
- enable, up/down direction and synchronous load
- wrap pulse and a sticky compare alarm

Sits beside the system timebase. It drives cur_time to display and scheduling logic, and raises alarm toward the controller FSM.

Parameters:
WIDTH, 16, bit width of cur_time, load_val and alarm_val.
PRESCALE, 1, clk cycles per count step; must be >= 1. A value of 1 counts every enabled cycle.
MAX_COUNT, 2**WIDTH-1, terminal count. The counter range is 0..MAX_COUNT; must be <= 2**WIDTH-1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous active-high reset.
en  input  1  count enable; low freezes the prescaler and counter.
dir  input  1  0 = count up, 1 = count down.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value loaded when load=1.
alarm_en  input  1  enables alarm setting.
alarm_val  input  WIDTH  compare value.
alarm_clr  input  1  clears the sticky alarm.
cur_time  output  WIDTH  current count, registered.
tick  output  1  one-cycle pulse in the cycle cur_time shows a stepped value.
wrap  output  1  one-cycle pulse in the cycle cur_time shows a wrapped value.
alarm  output  1  sticky alarm flag.

Behaviour:
- Reset: rst=1 at a rising edge sets cur_time=0, prescaler count=0, tick=0, wrap=0, alarm=0. This holds regardless of other inputs, including mid-count and mid-prescale.
- Priority per edge: rst > load > step.
- Prescaler: counter pc in 0..PRESCALE-1, width max(1,$clog2(PRESCALE)).
  - When en=1, pc increments.
  - step_req = en && pc==PRESCALE-1, then pc returns to 0.
  - When en=0, pc holds.
- Step, when step_req and not load:
  - Up: cur_time==MAX_COUNT goes to 0 with wrap=1; otherwise cur_time+1.
  - Down: cur_time==0 goes to MAX_COUNT with wrap=1; otherwise cur_time-1.
  - tick=1 on every step.
  - Latency: the new value, tick and wrap all appear together one cycle after the edge where step_req is sampled.
- Load: load=1 gives cur_time = min(load_val, MAX_COUNT) on the next cycle.
  - pc returns to 0; any pending step in that cycle is discarded.
  - tick=0, wrap=0.
  - Load works with en=0.
- tick and wrap are 0 in every cycle without a step. They never stay high for two consecutive cycles unless PRESCALE=1 and steps are consecutive.
- Alarm:
  - Sets when alarm_en=1 and a step produces a next value equal to alarm_val. alarm rises in the same cycle cur_time shows that value.
  - Loads never set the alarm.
  - alarm_clr=1 clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
  - alarm_en=0 blocks setting but does not clear an existing alarm.
- dir is sampled only at step edges. Changing dir between steps takes effect at the next step.
- Arithmetic is on WIDTH bits with explicit compare to MAX_COUNT; no reliance on natural overflow unless MAX_COUNT=2**WIDTH-1.
- Defaults (PRESCALE=1, full range, en=1, dir=0) give a free-running counter incrementing by one per clock from 0.

Decomposition:
- Package timekeeper_pkg holds:
  - DIR_UP=1'b0, DIR_DOWN=1'b1
  - default WIDTH
  - a function computing the prescaler width
- Sub-module tk_prescaler(clk, rst, en, clear, step) holds the pc counter.
  - clear is driven by load.
- Counter, wrap and alarm logic stay in the top.

Test Plan:
1. Defaults, rst high for 1 cycle then en=1, dir=0, for 12 cycles -> cur_time reads 1..12, tick=1 each cycle, wrap=0, alarm=0.
2. WIDTH=4, PRESCALE=3, MAX_COUNT=9, up from 0 for 30 cycles:
   - cur_time steps every 3rd cycle: 1..9, then 0.
   - wrap pulses exactly once at 9->0.
   - tick pulses 10 times.
3. Same config, load=1 with load_val=7 and dir=1 -> cur_time=7 the next cycle, then 6, 5, ... 0, then 9 with wrap=1.
   - load_val=15 -> cur_time clamps to 9.
4. Alarm, defaults, alarm_en=1, alarm_val=5, from 0:
   - alarm rises in the cycle cur_time=5 and stays high through 6, 7.
   - alarm_clr at cur_time=7 -> alarm=0 next cycle.
   - Loading 5 does not set alarm.
   - Set and clear in the same cycle -> alarm=1.
5. en toggling with PRESCALE=4:
   - en=0 for 5 cycles mid-prescale -> cur_time and pc hold.
   - After en returns to 1, the next step occurs after the remaining prescale cycles only.
6. rst asserted while cur_time=9, pc=2, alarm=1, with load=1 in the same cycle -> next cycle cur_time=0, tick=0, wrap=0, alarm=0.
